// File: rtl/coprocessor0_regfile.sv
// CP0 register file and exception/timer controller for the 5-stage MIPS core.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC and drives the IF redirect bus.
module coprocessor0_regfile #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic        exc_badvaddr_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    input  logic [5:0]  hw_interrupt,
    output logic [39:0] cp0_to_if_bus,
    output logic        flush
);

    localparam int unsigned     DIV_W      = (COUNT_DIVIDE > 2) ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(COUNT_DIVIDE - 1);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    // BEV is hard-wired to 1: only the bootstrap exception vector is supported.
    function automatic logic [31:0] pack_status(
        input logic [7:0] im,
        input logic       exl,
        input logic       ie
    );
        return {9'h000, 1'b1, 6'h00, im, 6'h00, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [7:0] ip,
        input logic [4:0] exccode
    );
        return {bd, ti, 14'h0000, ip, 1'b0, exccode, 2'b00};
    endfunction

    logic [31:0]      badvaddr_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic [31:0]      epc_r;
    logic [7:0]       status_im_r;
    logic             status_exl_r;
    logic             status_ie_r;
    logic             cause_bd_r;
    logic             cause_ti_r;
    logic [5:0]       cause_ip_hw_r;
    logic [1:0]       cause_ip_sw_r;
    logic [4:0]       cause_exccode_r;
    logic [DIV_W-1:0] phase_r;
    logic             flush_r;
    logic [31:0]      exception_address_r;

    logic             take_exc_s;
    logic             take_eret_s;
    logic             take_mtc0_s;
    logic             wr_count_s;
    logic             wr_compare_s;
    logic             wr_status_s;
    logic             wr_cause_s;
    logic             wr_epc_s;
    logic [7:0]       cause_ip_s;
    logic [7:0]       interrupt_valid_s;
    logic [31:0]      rdata_s;

    // Commit arbitration: exception beats eret beats mtc0; losers are dropped.
    always_comb begin
        take_exc_s   = exc_valid;
        take_eret_s  = ~exc_valid & eret_valid;
        take_mtc0_s  = ~exc_valid & ~eret_valid & mtc0_we;
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_status_s  = 1'b0;
        wr_cause_s   = 1'b0;
        wr_epc_s     = 1'b0;
        if (take_mtc0_s) begin
            case (cp0_addr)
                ADDR_COUNT:   wr_count_s   = 1'b1;
                ADDR_COMPARE: wr_compare_s = 1'b1;
                ADDR_STATUS:  wr_status_s  = 1'b1;
                ADDR_CAUSE:   wr_cause_s   = 1'b1;
                ADDR_EPC:     wr_epc_s     = 1'b1;
                default:      wr_count_s   = 1'b0;
            endcase
        end else begin
            wr_count_s = 1'b0;
        end
    end

    // mfc0 read mux and pending-interrupt vector, both from pre-edge state.
    always_comb begin
        cause_ip_s        = {cause_ip_hw_r, cause_ip_sw_r};
        interrupt_valid_s = cause_ip_s & status_im_r & {8{status_ie_r & ~status_exl_r}};
        case (cp0_addr)
            ADDR_BADVADDR: rdata_s = badvaddr_r;
            ADDR_COUNT:    rdata_s = count_r;
            ADDR_COMPARE:  rdata_s = compare_r;
            ADDR_STATUS:   rdata_s = pack_status(status_im_r, status_exl_r, status_ie_r);
            ADDR_CAUSE:    rdata_s = pack_cause(cause_bd_r, cause_ti_r, cause_ip_s, cause_exccode_r);
            ADDR_EPC:      rdata_s = epc_r;
            default:       rdata_s = 32'h0000_0000;
        endcase
    end

    assign cp0_rdata     = rdata_s;
    assign cp0_to_if_bus = {exception_address_r, interrupt_valid_s};
    assign flush         = flush_r;

    // Count and its prescaler; an mtc0 to Count restarts the prescale phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 32'h0000_0000;
            phase_r <= '0;
        end else if (wr_count_s) begin
            count_r <= cp0_wdata;
            phase_r <= '0;
        end else if (phase_r == PHASE_LAST) begin
            count_r <= count_r + 32'd1;
            phase_r <= '0;
        end else begin
            count_r <= count_r;
            phase_r <= phase_r + DIV_W'(1);
        end
    end

    // Compare register and the sticky timer interrupt it arms.
    always_ff @(posedge clock) begin
        if (reset) begin
            compare_r  <= 32'h0000_0000;
            cause_ti_r <= 1'b0;
        end else if (wr_compare_s) begin
            compare_r  <= cp0_wdata;
            cause_ti_r <= 1'b0;
        end else if (count_r == compare_r) begin
            compare_r  <= compare_r;
            cause_ti_r <= 1'b1;
        end else begin
            compare_r  <= compare_r;
            cause_ti_r <= cause_ti_r;
        end
    end

    // Interrupt pending bits: hardware lines sampled every cycle, timer folded into IP7.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_ip_hw_r <= 6'h00;
            cause_ip_sw_r <= 2'b00;
        end else begin
            cause_ip_hw_r <= {hw_interrupt[5] | cause_ti_r, hw_interrupt[4:0]};
            cause_ip_sw_r <= wr_cause_s ? cp0_wdata[9:8] : cause_ip_sw_r;
        end
    end

    // Status fields; EXL is set by exceptions and cleared by eret.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_im_r  <= 8'h00;
            status_exl_r <= 1'b0;
            status_ie_r  <= 1'b0;
        end else if (take_exc_s) begin
            status_exl_r <= 1'b1;
        end else if (take_eret_s) begin
            status_exl_r <= 1'b0;
        end else if (wr_status_s) begin
            status_im_r  <= cp0_wdata[15:8];
            status_exl_r <= cp0_wdata[1];
            status_ie_r  <= cp0_wdata[0];
        end else begin
            status_exl_r <= status_exl_r;
        end
    end

    // Exception capture; nested exceptions (EXL already set) keep the original EPC/BD.
    always_ff @(posedge clock) begin
        if (reset) begin
            epc_r           <= 32'h0000_0000;
            cause_bd_r      <= 1'b0;
            cause_exccode_r <= 5'd0;
            badvaddr_r      <= 32'h0000_0000;
        end else if (take_exc_s) begin
            cause_exccode_r <= exc_code;
            if (!status_exl_r) begin
                epc_r      <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                cause_bd_r <= exc_in_delay_slot;
            end else begin
                epc_r      <= epc_r;
                cause_bd_r <= cause_bd_r;
            end
            if (exc_badvaddr_we) begin
                badvaddr_r <= exc_badvaddr;
            end else begin
                badvaddr_r <= badvaddr_r;
            end
        end else if (wr_epc_s) begin
            epc_r <= cp0_wdata;
        end else begin
            epc_r <= epc_r;
        end
    end

    // Redirect to IF: one-cycle flush and a held target address.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_r             <= 1'b0;
            exception_address_r <= 32'h0000_0000;
        end else if (take_exc_s) begin
            flush_r             <= 1'b1;
            exception_address_r <= EXC_VECTOR;
        end else if (take_eret_s) begin
            flush_r             <= 1'b1;
            exception_address_r <= epc_r;
        end else begin
            flush_r             <= 1'b0;
            exception_address_r <= exception_address_r;
        end
    end

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Randomized self-checking bench for coprocessor0_regfile against a behavioural CP0 model.
`timescale 1ns/1ps
module tb_coprocessor0_regfile;

    logic        clock;
    logic        reset;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic        exc_badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [5:0]  hw_interrupt;
    logic [39:0] cp0_to_if_bus;
    logic        flush;

    coprocessor0_regfile dut (
        .clock(clock), .reset(reset), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_in_delay_slot(exc_in_delay_slot),
        .exc_badvaddr_we(exc_badvaddr_we), .exc_badvaddr(exc_badvaddr),
        .eret_valid(eret_valid), .hw_interrupt(hw_interrupt),
        .cp0_to_if_bus(cp0_to_if_bus), .flush(flush)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model state (field-level view of the architectural registers).
    bit          m_valid = 1'b0;
    logic [31:0] m_badvaddr, m_count, m_compare, m_epc, m_excaddr;
    logic [7:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd, m_ti, m_flush;
    logic [4:0]  m_exccode;
    int          m_phase;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badvaddr;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return 32'h0040_0000 | ({24'h0, m_im} << 8) | {30'h0, m_exl, m_ie};
            5'd13:   return ({31'h0, m_bd} << 31) | ({31'h0, m_ti} << 30) | ({24'h0, m_ip} << 8)
                            | ({27'h0, m_exccode} << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] m_ivalid();
        return (m_ie && !m_exl) ? (m_ip & m_im) : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_update();
        logic [31:0] n_count, n_compare, n_epc, n_bad, n_excaddr;
        logic [7:0]  n_im, n_ip;
        logic        n_exl, n_ie, n_bd, n_ti, n_flush;
        logic [4:0]  n_code;
        int          n_phase;
        bit          mt;
        if (reset) begin
            m_valid = 1'b1;
            m_badvaddr = 0; m_count = 0; m_compare = 0; m_epc = 0; m_excaddr = 0;
            m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_flush = 0;
            m_exccode = 0; m_phase = 0;
            return;
        end
        n_count = m_count; n_compare = m_compare; n_epc = m_epc; n_bad = m_badvaddr;
        n_excaddr = m_excaddr; n_im = m_im; n_ip = m_ip; n_exl = m_exl; n_ie = m_ie;
        n_bd = m_bd; n_code = m_exccode;
        mt = !exc_valid && !eret_valid && mtc0_we;
        if (exc_valid) begin
            n_code = exc_code;
            if (!m_exl) begin
                n_epc = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                n_bd  = exc_in_delay_slot;
            end
            n_exl = 1'b1;
            if (exc_badvaddr_we) n_bad = exc_badvaddr;
            n_flush = 1'b1; n_excaddr = 32'hBFC0_0380;
        end else if (eret_valid) begin
            n_exl = 1'b0; n_flush = 1'b1; n_excaddr = m_epc;
        end else begin
            n_flush = 1'b0;
            if (mt && cp0_addr == 5'd11) n_compare = cp0_wdata;
            if (mt && cp0_addr == 5'd12) begin
                n_im = cp0_wdata[15:8]; n_exl = cp0_wdata[1]; n_ie = cp0_wdata[0];
            end
            if (mt && cp0_addr == 5'd13) n_ip[1:0] = cp0_wdata[9:8];
            if (mt && cp0_addr == 5'd14) n_epc = cp0_wdata;
        end
        if (mt && cp0_addr == 5'd9) begin
            n_count = cp0_wdata; n_phase = 0;
        end else begin
            if (m_phase == 1) n_count = m_count + 32'd1;
            n_phase = (m_phase + 1) % 2;
        end
        if (mt && cp0_addr == 5'd11) n_ti = 1'b0;
        else n_ti = m_ti | (m_count == m_compare);
        n_ip[7:2] = {hw_interrupt[5] | m_ti, hw_interrupt[4:0]};
        m_count = n_count; m_compare = n_compare; m_epc = n_epc; m_badvaddr = n_bad;
        m_excaddr = n_excaddr; m_im = n_im; m_ip = n_ip; m_exl = n_exl; m_ie = n_ie;
        m_bd = n_bd; m_exccode = n_code; m_ti = n_ti; m_flush = n_flush; m_phase = n_phase;
    endtask

    // One cycle: compare DUT against the model mid-cycle, then clock both.
    task automatic step();
        @(negedge clock);
        if (m_valid) begin
            chk("model_rdata", {8'h0, cp0_rdata}, {8'h0, m_read(cp0_addr)});
            chk("model_bus", cp0_to_if_bus, {m_excaddr, m_ivalid()});
            chk("model_flush", {39'h0, flush}, {39'h0, m_flush});
        end
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; mtc0_we = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
        exc_badvaddr_we = 1'b0; exc_in_delay_slot = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        step();
        idle();
    endtask

    task automatic lit_rd(input string name, input logic [4:0] a, input logic [31:0] mask,
                          input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(name, {8'h0, cp0_rdata & mask}, {8'h0, exp});
    endtask

    logic [4:0] addr_tbl [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd9, 5'd3};

    initial begin
        bit          found;
        logic [31:0] cnt_at_ti;
        idle();
        cp0_addr = 5'd0; cp0_wdata = 32'h0; exc_code = 5'd0; exc_pc = 32'h0;
        exc_badvaddr = 32'h0; hw_interrupt = 6'h00;
        #1;
        reset = 1'b1;
        step();
        step();
        idle();
        // 1. reset state
        lit_rd("reset_status", 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
        lit_rd("reset_count", 5'd9, 32'hFFFF_FFFF, 32'h0);
        chk("reset_flush", {39'h0, flush}, 40'h0);
        chk("reset_ivalid", {32'h0, cp0_to_if_bus[7:0]}, 40'h0);
        step();

        // 2. timer
        mtc0(5'd9, 32'd10);
        mtc0(5'd11, 32'd14);
        lit_rd("ti_cleared", 5'd13, 32'h4000_0000, 32'h0);
        found = 1'b0; cnt_at_ti = 32'h0;
        for (int i = 0; i < 60 && !found; i++) begin
            cp0_addr = 5'd13;
            #1;
            if (cp0_rdata[30]) begin
                found = 1'b1;
                cp0_addr = 5'd9;
                #1;
                cnt_at_ti = cp0_rdata;
            end
            step();
        end
        chk("ti_seen", {39'h0, found}, 40'h1);
        chk("ti_count", {8'h0, cnt_at_ti}, 40'd14);
        mtc0(5'd11, 32'd100);
        lit_rd("ti_compare_clear", 5'd13, 32'h4000_0000, 32'h0);
        step();

        // 3. interrupt masking
        hw_interrupt = 6'b100000;
        mtc0(5'd12, 32'h0040_8001);
        chk("ivalid_on", {32'h0, cp0_to_if_bus[7:0]}, 40'h80);
        mtc0(5'd12, 32'h0040_8003);
        chk("ivalid_exl", {32'h0, cp0_to_if_bus[7:0]}, 40'h00);
        hw_interrupt = 6'h00;
        mtc0(5'd12, 32'h0000_0000);

        // 4. first exception in a delay slot
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h1000; exc_in_delay_slot = 1'b1;
        exc_badvaddr_we = 1'b1; exc_badvaddr = 32'h1003;
        step();
        idle();
        lit_rd("exc_epc", 5'd14, 32'hFFFF_FFFF, 32'h0000_0FFC);
        lit_rd("exc_bd_code", 5'd13, 32'h8000_007C, 32'h8000_0010);
        lit_rd("exc_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'h0000_1003);
        lit_rd("exc_exl", 5'd12, 32'h0000_0002, 32'h0000_0002);
        chk("exc_flush", {39'h0, flush}, 40'h1);
        chk("exc_vector", {8'h0, cp0_to_if_bus[39:8]}, {8'h0, 32'hBFC0_0380});
        step();
        chk("exc_flush_drop", {39'h0, flush}, 40'h0);

        // 5. nested exception, then eret
        exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h2000;
        step();
        idle();
        lit_rd("nested_epc", 5'd14, 32'hFFFF_FFFF, 32'h0000_0FFC);
        step();
        eret_valid = 1'b1;
        step();
        idle();
        lit_rd("eret_exl", 5'd12, 32'h0000_0002, 32'h0);
        chk("eret_addr", {8'h0, cp0_to_if_bus[39:8]}, {8'h0, 32'h0000_0FFC});
        chk("eret_flush", {39'h0, flush}, 40'h1);
        step();

        // 6. exception beats eret and mtc0 in the same cycle
        exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h3000; exc_in_delay_slot = 1'b0;
        eret_valid = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h55;
        step();
        idle();
        lit_rd("prio_epc", 5'd14, 32'hFFFF_FFFF, 32'h0000_3000);
        lit_rd("prio_exl", 5'd12, 32'h0000_0002, 32'h0000_0002);
        chk("prio_addr", {8'h0, cp0_to_if_bus[39:8]}, {8'h0, 32'hBFC0_0380});
        step();

        // reset overrides a concurrent exception
        exc_valid = 1'b1; reset = 1'b1;
        step();
        idle();
        chk("rst_exc_flush", {39'h0, flush}, 40'h0);
        lit_rd("rst_exc_status", 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            reset             = ($urandom_range(0, 199) == 0);
            exc_valid         = ($urandom_range(0, 15) == 0);
            eret_valid        = ($urandom_range(0, 11) == 0);
            mtc0_we           = ($urandom_range(0, 2) == 0);
            cp0_addr          = addr_tbl[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) cp0_addr = 5'($urandom_range(0, 31));
            cp0_wdata         = $urandom_range(0, 1) ? $urandom : (m_compare - 32'($urandom_range(0, 6)));
            exc_code          = 5'($urandom_range(0, 31));
            exc_pc            = $urandom & 32'hFFFF_FFFC;
            exc_in_delay_slot = $urandom_range(0, 1) == 1;
            exc_badvaddr_we   = $urandom_range(0, 1) == 1;
            exc_badvaddr      = $urandom;
            hw_interrupt      = 6'($urandom_range(0, 63));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
